// File: rtl/port_rd_sram_selector.sv
// Egress read-side SRAM selector: scans the shared per-SRAM status bus one SRAM per cycle
// and issues a held read request. Define RD_SELECT_STICKY_EN to enable sticky reuse (modes 2/3).
module port_rd_sram_selector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] select_mode,
  input  logic [4:0] select_threshold,
  input  logic       select_enable,
  input  logic       viscous,
  output logic [4:0] scan_sram,
  input  logic [8:0] scan_amount,
  input  logic       scan_busy,
  output logic       rd_req,
  output logic [4:0] rd_sram,
  input  logic       rd_ack,
  output logic       sel_done,
  output logic [1:0] sel_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] rr_ptr;
  logic [4:0] tick;
  logic       found;
  logic [4:0] best_sram;
  logic [8:0] best_amount;
  logic       mode_max;
  logic       take;
  logic       commit;

  assign sel_state = state;
  assign mode_max  = (select_mode != 2'd0);
  assign take      = !scan_busy && (scan_amount != '0) &&
                     (mode_max ? (scan_amount > best_amount) : !found);
  assign commit    = found && (!mode_max || (tick >= select_threshold));

`ifdef RD_SELECT_STICKY_EN
  logic [4:0] last_sram;
  logic [8:0] sticky_remaining;
  logic       sticky_valid;
  logic       from_sticky;
  logic       sticky_hit;

  assign sticky_hit = select_mode[1] && viscous && sticky_valid && (sticky_remaining != '0);
`else
  logic unused_viscous;
  assign unused_viscous = viscous;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_req      <= 1'b0;
      rd_sram     <= '0;
      scan_sram   <= '0;
      sel_done    <= 1'b0;
      rr_ptr      <= '1;
      tick        <= '0;
      found       <= 1'b0;
      best_sram   <= '0;
      best_amount <= '0;
`ifdef RD_SELECT_STICKY_EN
      last_sram        <= '0;
      sticky_remaining <= '0;
      sticky_valid     <= 1'b0;
      from_sticky      <= 1'b0;
`endif
    end else begin
      sel_done <= 1'b0;
`ifdef RD_SELECT_STICKY_EN
      // Dropping out of the sticky modes invalidates any remembered SRAM.
      if (!select_mode[1]) sticky_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (select_enable) begin
`ifdef RD_SELECT_STICKY_EN
            if (sticky_hit) begin
              rd_sram     <= last_sram;
              rd_req      <= 1'b1;
              from_sticky <= 1'b1;
              state       <= READ;
            end else
`endif
            begin
              scan_sram   <= rr_ptr + 5'd1;
              tick        <= '0;
              found       <= 1'b0;
              best_amount <= '0;
              state       <= SCAN;
            end
          end
        end
        SCAN: begin
          scan_sram <= scan_sram + 5'd1;
          if (tick != 5'd31) tick <= tick + 5'd1;
          // Candidate frozen on the commit cycle so best_amount matches rd_sram.
          if (take && !commit) begin
            best_sram   <= scan_sram;
            best_amount <= scan_amount;
            found       <= 1'b1;
          end
          if (!select_enable) begin
            state <= IDLE;
          end else if (commit) begin
            rd_sram <= best_sram;
            rd_req  <= 1'b1;
`ifdef RD_SELECT_STICKY_EN
            from_sticky <= 1'b0;
`endif
            state   <= READ;
          end
        end
        READ: begin
          if (rd_ack) begin
            rd_req   <= 1'b0;
            sel_done <= 1'b1;
            rr_ptr   <= rd_sram;
            state    <= DONE;
`ifdef RD_SELECT_STICKY_EN
            if (from_sticky) begin
              sticky_remaining <= sticky_remaining - 9'd1;
              if (sticky_remaining == 9'd1) sticky_valid <= 1'b0;
            end else begin
              last_sram        <= rd_sram;
              sticky_remaining <= best_amount - 9'd1;
              sticky_valid     <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
